// File: rtl/svi_capture_bank_pkg.sv
// rtl/svi_capture_bank_pkg.sv - shared defaults, index-width helper and report FSM states
package svi_capture_bank_pkg;

   localparam int SVI_N_CHAN_DEF = 4;
   localparam int SVI_WIDTH_DEF  = 8;

   // Width of a channel index; never below 1 so a 2-channel bank still has a port bit.
   function automatic int chan_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/svi_capture_bank_rr_arbiter.sv
// rtl/svi_capture_bank_rr_arbiter.sv - round-robin arbiter with registered last-grant pointer
//   i_clk, i_srst    : clock, synchronous active-high reset
//   i_req            : per-channel request
//   i_grant_en       : commit the current winner (advances the pointer)
//   o_grant_idx      : index of the current winner (valid when o_any)
//   o_any            : at least one request present
module rr_arbiter
   import svi_capture_bank_pkg::*;
#(
   parameter int N_CHAN = SVI_N_CHAN_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_srst,
   input  logic [N_CHAN-1:0]         i_req,
   input  logic                      i_grant_en,
   output logic [chan_w(N_CHAN)-1:0] o_grant_idx,
   output logic                      o_any
);

   localparam int CW = chan_w(N_CHAN);

   logic [CW-1:0] last_q;

   assign o_any = |i_req;

   // Search begins one past the last grant and wraps, so the previous winner has lowest priority.
   always_comb begin
      int  j;
      logic found;
      j           = 0;
      found       = 1'b0;
      o_grant_idx = '0;
      for (int off = 1; off <= N_CHAN; off++) begin
         j = int'(last_q) + off;
         if (j >= N_CHAN) j = j - N_CHAN;
         if (!found && i_req[CW'(j)]) begin
            found       = 1'b1;
            o_grant_idx = CW'(j);
         end
      end
   end

   // Reset points at the top channel so channel 0 wins first.
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         last_q <= CW'(N_CHAN - 1);
      end else if (i_grant_en && o_any) begin
         last_q <= o_grant_idx;
      end
   end

endmodule

// File: rtl/svi_capture_bank.sv
// rtl/svi_capture_bank.sv - per-channel capture registers with round-robin change reporting
//   i_clk, i_srst : clock, synchronous active-high reset
//   i_x           : per-channel source values (channel k at [k*WIDTH +: WIDTH])
//   i_capture     : per-channel capture enable
//   o_y           : per-channel held values
//   o_pending     : per-channel changed-but-not-reported flags
//   o_valid       : report available; i_ready accepts it
//   o_chan/o_data : reported channel and its held value at selection time
module svi_capture_bank
   import svi_capture_bank_pkg::*;
#(
   parameter int N_CHAN = SVI_N_CHAN_DEF,
   parameter int WIDTH  = SVI_WIDTH_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_srst,
   input  logic [N_CHAN*WIDTH-1:0]   i_x,
   input  logic [N_CHAN-1:0]         i_capture,
   output logic [N_CHAN*WIDTH-1:0]   o_y,
   output logic [N_CHAN-1:0]         o_pending,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [chan_w(N_CHAN)-1:0] o_chan,
   output logic [WIDTH-1:0]          o_data
);

   localparam int CW = chan_w(N_CHAN);

   logic [WIDTH-1:0]  x_arr [N_CHAN];
   logic [WIDTH-1:0]  y_q   [N_CHAN];
   logic [N_CHAN-1:0] pend_q;
   logic [N_CHAN-1:0] pend_nxt;
   state_t            state_q;
   logic              valid_q;
   logic [CW-1:0]     chan_q;
   logic [WIDTH-1:0]  data_q;
   logic [CW-1:0]     grant_idx;
   logic              any_pend;
   logic              grant_fire;

   for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
      assign x_arr[k]                 = i_x[k*WIDTH +: WIDTH];
      assign o_y[k*WIDTH +: WIDTH]    = y_q[k];
   end

   assign o_pending = pend_q;
   assign o_valid   = valid_q;
   assign o_chan    = chan_q;
   assign o_data    = data_q;

   rr_arbiter #(
      .N_CHAN (N_CHAN)
   ) u_arb (
      .i_clk       (i_clk),
      .i_srst      (i_srst),
      .i_req       (pend_q),
      .i_grant_en  (grant_fire),
      .o_grant_idx (grant_idx),
      .o_any       (any_pend)
   );

   // A new report is selected from IDLE, or from PRESENT on the accepting edge.
   assign grant_fire = any_pend && ((state_q == ST_IDLE) || i_ready);

   // Grant clears first; a value-changing capture on the same edge re-sets the bit.
   always_comb begin
      pend_nxt = pend_q;
      if (grant_fire) pend_nxt[grant_idx] = 1'b0;
      for (int k = 0; k < N_CHAN; k++) begin
         if (i_capture[k] && (x_arr[k] != y_q[k])) pend_nxt[k] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         chan_q  <= '0;
         data_q  <= '0;
         pend_q  <= '0;
         for (int k = 0; k < N_CHAN; k++) y_q[k] <= '0;
      end else begin
         pend_q <= pend_nxt;
         for (int k = 0; k < N_CHAN; k++) begin
            if (i_capture[k]) y_q[k] <= x_arr[k];
         end
         // o_data takes the pre-edge held value, so a same-edge capture never leaks into it.
         case (state_q)
            ST_IDLE: begin
               if (grant_fire) begin
                  state_q <= ST_PRESENT;
                  valid_q <= 1'b1;
                  chan_q  <= grant_idx;
                  data_q  <= y_q[grant_idx];
               end
            end
            ST_PRESENT: begin
               if (grant_fire) begin
                  chan_q  <= grant_idx;
                  data_q  <= y_q[grant_idx];
               end else if (i_ready) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_svi_capture_bank.sv
// tb/tb_svi_capture_bank.sv - directed self-checking bench for svi_capture_bank
module tb_svi_capture_bank;

   localparam int N = 4;
   localparam int W = 8;

   logic           i_clk = 1'b0;
   logic           i_srst;
   logic [N*W-1:0] i_x;
   logic [N-1:0]   i_capture;
   logic [N*W-1:0] o_y;
   logic [N-1:0]   o_pending;
   logic           o_valid;
   logic           i_ready;
   logic [1:0]     o_chan;
   logic [W-1:0]   o_data;

   int total = 0;
   int fails = 0;

   svi_capture_bank #(.N_CHAN(N), .WIDTH(W)) dut (
      .i_clk     (i_clk),
      .i_srst    (i_srst),
      .i_x       (i_x),
      .i_capture (i_capture),
      .o_y       (o_y),
      .o_pending (o_pending),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_chan    (o_chan),
      .o_data    (o_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_x(input int k, input logic [W-1:0] v);
      i_x[k*W +: W] = v;
   endtask

   function automatic logic [W-1:0] y_of(input int k);
      return o_y[k*W +: W];
   endfunction

   task automatic chk_rep(input string tag, input logic v, input logic [1:0] c, input logic [W-1:0] d);
      chk({tag, "_valid"}, o_valid, v);
      chk({tag, "_chan"},  o_chan,  c);
      chk({tag, "_data"},  o_data,  d);
   endtask

   initial begin
      i_srst = 1'b1; i_x = '0; i_capture = '0; i_ready = 1'b0;
      tick(); tick();
      chk("rst_y", o_y, 0);
      chk("rst_pending", o_pending, 0);
      chk_rep("rst", 1'b0, 2'd0, 8'h00);

      // Equal-value capture (0 over reset value 0) sets nothing.
      i_srst = 1'b0; i_capture = 4'b0010;
      tick();
      chk("same_pending", o_pending, 0);
      i_capture = '0;
      tick();
      chk("same_valid", o_valid, 0);

      // Single capture on channel 2.
      set_x(2, 8'hA5); i_capture = 4'b0100; i_ready = 1'b1;
      tick();
      chk("c2_y", y_of(2), 8'hA5);
      chk("c2_pending", o_pending, 4'b0100);
      chk("c2_valid0", o_valid, 0);
      i_capture = '0;
      tick();
      chk_rep("c2_rep", 1'b1, 2'd2, 8'hA5);
      chk("c2_pend_clr", o_pending, 0);
      tick();
      chk("c2_idle", o_valid, 0);

      // Fresh reset, then all four channels at once drain 0,1,2,3 back-to-back.
      i_srst = 1'b1;
      tick();
      i_srst = 1'b0;
      set_x(0, 8'h11); set_x(1, 8'h22); set_x(2, 8'h33); set_x(3, 8'h44);
      i_capture = 4'b1111;
      tick();
      chk("all_pending", o_pending, 4'b1111);
      chk("all_valid0", o_valid, 0);
      i_capture = '0;
      tick(); chk_rep("all0", 1'b1, 2'd0, 8'h11); chk("all0_pend", o_pending, 4'b1110);
      tick(); chk_rep("all1", 1'b1, 2'd1, 8'h22);
      tick(); chk_rep("all2", 1'b1, 2'd2, 8'h33);
      tick(); chk_rep("all3", 1'b1, 2'd3, 8'h44); chk("all3_pend", o_pending, 0);
      tick(); chk("all_idle", o_valid, 0);

      // Backpressure: channel 1 goes 22->11, presented, then re-captured 22 while stalled.
      i_ready = 1'b0; set_x(1, 8'h11); i_capture = 4'b0010;
      tick();
      chk("bp_pending", o_pending, 4'b0010);
      i_capture = '0;
      tick();
      chk_rep("bp_first", 1'b1, 2'd1, 8'h11);
      set_x(1, 8'h22); i_capture = 4'b0010;
      tick();
      chk_rep("bp_recap", 1'b1, 2'd1, 8'h11);
      chk("bp_repend", o_pending, 4'b0010);
      i_capture = '0;
      tick(); tick(); tick();
      chk_rep("bp_hold", 1'b1, 2'd1, 8'h11);
      i_ready = 1'b1;
      tick();
      chk_rep("bp_second", 1'b1, 2'd1, 8'h22);
      chk("bp_pend_clr", o_pending, 0);
      tick();
      chk("bp_idle", o_valid, 0);

      // Set wins over grant-clear on the same channel and edge.
      i_ready = 1'b0; set_x(0, 8'h55); i_capture = 4'b0001;
      tick();
      set_x(0, 8'h66); i_capture = 4'b0001;
      tick();
      chk_rep("sw_rep", 1'b1, 2'd0, 8'h55);
      chk("sw_pending", o_pending, 4'b0001);
      i_capture = '0; i_ready = 1'b1;
      tick();
      chk_rep("sw_again", 1'b1, 2'd0, 8'h66);
      tick();
      chk("sw_idle", o_valid, 0);

      // Reset with a report in flight and two channels still pending; capture in reset ignored.
      i_ready = 1'b0;
      set_x(1, 8'hAA); set_x(2, 8'h77); set_x(3, 8'h88); i_capture = 4'b1110;
      tick();
      i_capture = '0;
      tick();
      chk_rep("rf_pre", 1'b1, 2'd1, 8'hAA);
      chk("rf_pre_pend", o_pending, 4'b1100);
      i_srst = 1'b1; i_ready = 1'b1; set_x(1, 8'h99); i_capture = 4'b0010;
      tick();
      chk("rf_y", o_y, 0);
      chk("rf_pending", o_pending, 0);
      chk_rep("rf_rst", 1'b0, 2'd0, 8'h00);
      i_srst = 1'b0; i_capture = '0;
      set_x(0, 8'h01); set_x(3, 8'h03); i_capture = 4'b1001;
      tick();
      i_capture = '0;
      tick();
      chk_rep("rf_first", 1'b1, 2'd0, 8'h01);
      tick();
      chk_rep("rf_next", 1'b1, 2'd3, 8'h03);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/svi_capture_bank.md
SVI_CAPTURE_BANK -- requirements
Module: svi_capture_bank

Interface
REQ-001 Parameter N_CHAN, default 4: number of channels; legal range 2..32.
REQ-002 Parameter WIDTH, default 8: data width per channel; legal range 1..64.
REQ-003 Port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port i_srst, input, 1: reset, synchronous and active-high.
REQ-005 Port i_x, input, N_CHAN x WIDTH: per-channel source value.
REQ-006 Port i_capture, input, N_CHAN: per-channel capture enable.
REQ-007 Port o_y, output, N_CHAN x WIDTH: per-channel held value.
REQ-008 Port o_pending, output, N_CHAN: per-channel changed-but-not-reported flag.
REQ-009 Port o_valid, output, 1: report available.
REQ-010 Port i_ready, input, 1: consumer accepts report.
REQ-011 Port o_chan, output, clog2(N_CHAN): channel index of the current report.
REQ-012 Port o_data, output, WIDTH: held value of that channel at report selection.

Function
REQ-013 Flop-based capture, no latches: i_capture[k]=1 at edge t SHALL make o_y[k]=i_x[k] after t (1-cycle latency); otherwise o_y[k] holds.
REQ-014 Capture SHALL set pending[k] only if i_x[k] differs from the current o_y[k]; an equal-value capture leaves pending[k] unchanged.
REQ-015 Report FSM states IDLE (o_valid=0) and PRESENT (o_valid=1).
REQ-016 IDLE -> PRESENT when any pending bit is set: grant the round-robin winner g, load o_chan=g and o_data=o_y[g], clear pending[g]; o_valid rises 1 cycle after pending[g] becomes visible.
REQ-017 Round-robin: search starts at index (last_grant+1) mod N_CHAN and wraps; last_grant updates on every grant.
REQ-018 PRESENT: o_valid, o_chan and o_data SHALL be stable while i_ready=0.
REQ-019 PRESENT with i_ready=1: handshake completes; if any pending bit is set at that edge, grant the next winner back-to-back (o_valid stays 1); else -> IDLE.
REQ-020 Simultaneous grant-clear and value-changing capture on the same channel: set wins; pending[g] stays 1 and the channel is reported again later.
REQ-021 A capture on the presented channel during PRESENT SHALL NOT alter o_data; it only sets pending per REQ-014.
REQ-022 i_ready while o_valid=0 is ignored.
REQ-023 Captures on all N_CHAN channels in one cycle are all recorded; with no further changes, reports drain in round-robin order, one per accepted handshake.

Reset
REQ-024 i_srst=1 at an edge: o_y=0, o_pending=0, o_valid=0, o_chan=0, o_data=0, last_grant=N_CHAN-1 (channel 0 has first priority), FSM=IDLE.
REQ-025 Reset dominates every capture and handshake in the same cycle; a report in flight is dropped, not completed.
REQ-026 Captures are ignored in the reset cycle; normal operation starts at the first edge with i_srst=0.

Structure
REQ-027 The shared package holds the N_CHAN/WIDTH defaults, the channel-index width function, and the report FSM state enum.
REQ-028 One sub-module, rr_arbiter (N_CHAN request/grant, last_grant pointer, grant-enable input); all capture and FSM logic stays in svi_capture_bank.

Verification
REQ-029 Reset then i_capture[2]=1, i_x[2]=8'hA5, i_ready=1 -> o_y[2]=A5 after 1 cycle, o_pending[2]=1; next cycle o_valid=1, o_chan=2, o_data=A5.
REQ-030 All 4 channels captured with nonzero values in one cycle, i_ready=1 -> reports in order 0,1,2,3 back-to-back, o_valid high for 4 consecutive cycles.
REQ-031 i_ready=0 for 5 cycles during PRESENT, channel re-captured 8'h11->8'h22 -> o_data holds 11; after acceptance, a second report for the same channel shows 22.
REQ-032 Capture of the same value as o_y (e.g. 0 after reset) -> o_pending stays 0 and o_valid stays 0.
REQ-033 i_srst asserted while o_valid=1 with 2 channels pending -> next cycle all outputs 0; after release, channel 0 wins the first grant.
REQ-034 Random capture/ready stress, N_CHAN=8, WIDTH=16, 10k cycles -> scoreboard: every value change reported at least once, in round-robin order; no report while o_pending=0; o_data/o_chan stable under backpressure.
